// File: rtl/io_cmd_sequencer.sv
// Front-panel command sequencer: synchronizes and debounces the load/clear switches,
// arbitrates clear-over-load and issues one-cycle dmem strobes separated by a hold-off.

module io_cmd_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d  = raw;
        s2_d  = s1_q;
        db_d  = db_q;
        cnt_d = cnt_q;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Flags the edge on which the debounced level flips 0->1.
    assign rise = db_d & ~db_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

module io_cmd_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_load_raw,
    input  logic       sw_clear_raw,
    output logic       load_en,
    output logic       clear_en,
    output logic       busy,
    output logic [7:0] cmd_count,
    output logic [1:0] last_cmd
);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HW-1:0] HO_LAST = HW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE_LOAD  = 2'd1,
        ISSUE_CLEAR = 2'd2,
        HOLDOFF     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          req_load_q, req_load_d;
    logic          req_clear_q, req_clear_d;
    logic [7:0]    cmd_count_q, cmd_count_d;
    logic [1:0]    last_cmd_q, last_cmd_d;
    logic          load_rise, clear_rise;
    logic          take_load, take_clear;

    io_cmd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk   (clk),
        .reset (reset),
        .raw   (sw_load_raw),
        .rise  (load_rise)
    );

    io_cmd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .reset (reset),
        .raw   (sw_clear_raw),
        .rise  (clear_rise)
    );

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        cmd_count_d = cmd_count_q;
        last_cmd_d  = last_cmd_q;
        take_load   = 1'b0;
        take_clear  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_clear_q) begin
                    state_d     = ISSUE_CLEAR;
                    take_clear  = 1'b1;
                    last_cmd_d  = 2'b10;
                    cmd_count_d = cmd_count_q + 8'd1;
                end else if (req_load_q) begin
                    state_d     = ISSUE_LOAD;
                    take_load   = 1'b1;
                    last_cmd_d  = 2'b01;
                    cmd_count_d = cmd_count_q + 8'd1;
                end
            end
            ISSUE_LOAD, ISSUE_CLEAR: begin
                state_d = HOLDOFF;
                hcnt_d  = '0;
            end
            HOLDOFF: begin
                if (hcnt_q == HO_LAST) begin
                    state_d = IDLE;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Requests are one deep; a fresh rise on the consuming edge re-arms the request.
        req_load_d  = (req_load_q & ~take_load) | load_rise;
        req_clear_d = (req_clear_q & ~take_clear) | clear_rise;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hcnt_q      <= '0;
            req_load_q  <= 1'b0;
            req_clear_q <= 1'b0;
            cmd_count_q <= 8'd0;
            last_cmd_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            req_load_q  <= req_load_d;
            req_clear_q <= req_clear_d;
            cmd_count_q <= cmd_count_d;
            last_cmd_q  <= last_cmd_d;
        end
    end

    assign load_en   = (state_q == ISSUE_LOAD);
    assign clear_en  = (state_q == ISSUE_CLEAR);
    assign busy      = (state_q != IDLE);
    assign cmd_count = cmd_count_q;
    assign last_cmd  = last_cmd_q;
endmodule
